// File: rtl/pwm_capture.sv
// PWM receiver: synchronises pwm_in, measures period and high time between rising
// edges, and reports duty as an integer percent through a serial restoring divider.
module pwm_capture #(
    parameter int CNT_W       = 20,
    parameter int TIMEOUT     = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [6:0]       duty_pct,
    output logic [CNT_W-1:0] period,
    output logic             duty_valid,
    output logic             signal_lost
);

    localparam int NW      = CNT_W + 7;
    localparam int DIV_CYC = NW;
    localparam int STEP_W  = $clog2(DIV_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hi;
    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_div;
    logic [NW-1:0]          r_quot;
    logic [CNT_W-1:0]       r_rem;
    logic [STEP_W-1:0]      r_step;
    logic [6:0]             r_duty;
    logic [CNT_W-1:0]       r_period;
    logic                   r_valid;
    logic                   r_lost;

    logic                   w_s;
    logic                   w_re;
    logic                   w_timeout;
    logic                   w_last;
    logic [NW-1:0]          w_dividend;
    logic [CNT_W:0]         w_rem_sh;
    logic                   w_ge;
    logic [NW-1:0]          w_quot_nx;
    logic [6:0]             w_duty_q;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_re       = w_s & ~r_s_prev;
    assign w_timeout  = (r_cnt == TIMEOUT_C);
    assign w_last     = (r_step == STEP_W'(DIV_CYC - 1));
    assign w_dividend = NW'(r_hi) * NW'(100);

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign w_rem_sh  = {r_rem, r_quot[NW-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_div});
    assign w_quot_nx = {r_quot[NW-2:0], w_ge};
    assign w_duty_q  = (w_quot_nx > NW'(100)) ? 7'd100 : w_quot_nx[6:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_re) w_state_next = MEASURE;
            end
            MEASURE: begin
                if (w_re)           w_state_next = DIVIDE;
                else if (w_timeout) w_state_next = IDLE;
            end
            DIVIDE: begin
                if (w_last) w_state_next = MEASURE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync   <= '0;
            r_s_prev <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_div    <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_step   <= '0;
            r_duty   <= 7'd0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_lost   <= 1'b1;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_s_prev <= w_s;
            r_valid  <= 1'b0;

            // Counters restart on every edge, even mid-division, so the next period is exact.
            if (w_re) begin
                r_cnt <= CNT_W'(1);
                r_hi  <= CNT_W'(1);
            end else begin
                if (r_cnt != TIMEOUT_C) r_cnt <= r_cnt + CNT_W'(1);
                if (w_s && r_hi != CNT_MAX) r_hi <= r_hi + CNT_W'(1);
            end

            case (r_state)
                MEASURE: begin
                    if (w_re) begin
                        r_div  <= r_cnt;
                        r_quot <= w_dividend;
                        r_rem  <= '0;
                        r_step <= '0;
                    end else if (w_timeout) begin
                        r_duty   <= w_s ? 7'd100 : 7'd0;
                        r_period <= '0;
                        r_lost   <= 1'b1;
                        r_valid  <= 1'b1;
                    end
                end
                DIVIDE: begin
                    r_quot <= w_quot_nx;
                    r_rem  <= w_ge ? CNT_W'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[CNT_W-1:0];
                    r_step <= r_step + STEP_W'(1);
                    if (w_last) begin
                        r_duty   <= w_duty_q;
                        r_period <= r_div;
                        r_lost   <= 1'b0;
                        r_valid  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign duty_pct    = r_duty;
    assign period      = r_period;
    assign duty_valid  = r_valid;
    assign signal_lost = r_lost;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: waveforms with hand-computed duty/period and
// result timing, timeout, reset abort, short periods and an asynchronous-phase input.
module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;
    localparam int SYNC    = 2;
    localparam int LAT     = 26;    // drive edge -> duty_valid: 2 sync + 24 (detect + 23 divide steps)
    localparam int TO_LAT  = 1003;  // drive edge -> timeout pulse: 2 sync + 1000 + 1

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic [6:0]       duty_pct;
    logic [CNT_W-1:0] period;
    logic             duty_valid;
    logic             signal_lost;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int consec = 0;
    logic prev_dv = 1'b0;
    int edge_q[$];
    int pulse_cyc_q[$];
    int pulse_duty_q[$];
    int pulse_per_q[$];
    int pulse_lost_q[$];

    pwm_capture #(
        .CNT_W(CNT_W),
        .TIMEOUT(TIMEOUT),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pwm_in(pwm_in),
        .duty_pct(duty_pct),
        .period(period),
        .duty_valid(duty_valid),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (duty_valid === 1'b1) begin
            pulse_cyc_q.push_back(cyc);
            pulse_duty_q.push_back(int'(duty_pct));
            pulse_per_q.push_back(int'(period));
            pulse_lost_q.push_back(int'(signal_lost));
            if (prev_dv) consec++;
        end
        prev_dv = (duty_valid === 1'b1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_rec();
        edge_q.delete();
        pulse_cyc_q.delete();
        pulse_duty_q.delete();
        pulse_per_q.delete();
        pulse_lost_q.delete();
    endtask

    task automatic check_pulse(input string tag, input int idx, input int exp_cyc,
                               input int exp_duty, input int exp_per, input int exp_lost);
        check({tag, "_present"}, 32'(idx < pulse_duty_q.size()), 1);
        if (idx < pulse_duty_q.size()) begin
            check({tag, "_cycle"}, pulse_cyc_q[idx], exp_cyc);
            check({tag, "_duty"}, pulse_duty_q[idx], exp_duty);
            check({tag, "_period"}, pulse_per_q[idx], exp_per);
            check({tag, "_lost"}, pulse_lost_q[idx], exp_lost);
        end
    endtask

    // Starts just after a negedge with pwm_in low; records the cycle of every rising drive.
    task automatic drive_pwm(input int per, input int hi, input int n);
        for (int p = 0; p < n; p++) begin
            pwm_in = 1'b1;
            edge_q.push_back(cyc);
            repeat (hi) @(negedge clk);
            pwm_in = 1'b0;
            repeat (per - hi) @(negedge clk);
        end
    endtask

    initial begin
        int ph;
        int k;
        rst = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_duty", duty_pct, 0);
        check("rst_period", period, 0);
        check("rst_valid", duty_valid, 0);
        check("rst_lost", signal_lost, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 200/50: first edge only arms
        clear_rec();
        drive_pwm(200, 50, 4);
        check("p200_count", pulse_duty_q.size(), 3);
        for (int i = 0; i < 3; i++) check_pulse("p200", i, edge_q[i+1] + LAT, 25, 200, 0);

        // 300/100 -> 33 (floor); first pulse closes the last 200/50 period
        clear_rec();
        drive_pwm(300, 100, 3);
        check("p300_count", pulse_duty_q.size(), 3);
        check_pulse("p300_prev", 0, edge_q[0] + LAT, 25, 200, 0);
        check_pulse("p300_a", 1, edge_q[1] + LAT, 33, 300, 0);
        check_pulse("p300_b", 2, edge_q[2] + LAT, 33, 300, 0);

        // 100/99 -> 99
        clear_rec();
        drive_pwm(100, 99, 3);
        check("p100_count", pulse_duty_q.size(), 3);
        check_pulse("p100_prev", 0, edge_q[0] + LAT, 33, 300, 0);
        check_pulse("p100_a", 1, edge_q[1] + LAT, 99, 100, 0);
        check_pulse("p100_b", 2, edge_q[2] + LAT, 99, 100, 0);

        // 50% then hold high -> timeout reports 100%
        clear_rec();
        drive_pwm(100, 50, 2);
        check("half_count", pulse_duty_q.size(), 2);
        check_pulse("half", 1, edge_q[1] + LAT, 50, 100, 0);
        clear_rec();
        pwm_in = 1'b1;
        edge_q.push_back(cyc);
        repeat (2500) @(negedge clk);
        check("hold1_count", pulse_duty_q.size(), 2);
        check_pulse("hold1_last", 0, edge_q[0] + LAT, 50, 100, 0);
        check_pulse("hold1_to", 1, edge_q[0] + TO_LAT, 100, 0, 1);
        check("hold1_lost_live", signal_lost, 1);
        check("hold1_duty_live", duty_pct, 100);
        pwm_in = 1'b0;
        @(negedge clk);

        // From IDLE: re-arm, two results, then hold low -> timeout reports 0%
        clear_rec();
        drive_pwm(100, 50, 3);
        repeat (2500) @(negedge clk);
        check("hold0_count", pulse_duty_q.size(), 3);
        check_pulse("hold0_a", 0, edge_q[1] + LAT, 50, 100, 0);
        check_pulse("hold0_b", 1, edge_q[2] + LAT, 50, 100, 0);
        check_pulse("hold0_to", 2, edge_q[2] + TO_LAT, 0, 0, 1);
        check("hold0_lost_live", signal_lost, 1);
        check("hold0_duty_live", duty_pct, 0);

        // Period 10 shorter than the divider: edges during DIVIDE are dropped
        clear_rec();
        drive_pwm(10, 5, 10);
        check("p10_count", pulse_duty_q.size(), 3);
        check_pulse("p10_a", 0, edge_q[1] + LAT, 50, 10, 0);
        check_pulse("p10_b", 1, edge_q[4] + LAT, 50, 10, 0);
        check_pulse("p10_c", 2, edge_q[7] + LAT, 50, 10, 0);

        // Reset mid-division aborts the result
        clear_rec();
        k = cyc;
        pwm_in = 1'b1;
        edge_q.push_back(k);
        repeat (5) @(negedge clk);
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_duty", duty_pct, 0);
        check("mid_rst_period", period, 0);
        check("mid_rst_valid", duty_valid, 0);
        check("mid_rst_lost", signal_lost, 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        drive_pwm(100, 50, 3);
        check("after_rst_count", pulse_duty_q.size(), 2);
        check_pulse("after_rst_a", 0, edge_q[2] + LAT, 50, 100, 0);
        check_pulse("after_rst_b", 1, edge_q[3] + LAT, 50, 100, 0);
        check("after_rst_lost_live", signal_lost, 0);

        // Asynchronous phase 1000/250; go idle first so the first edge only arms
        repeat (1100) @(negedge clk);
        check("pre_async_lost", signal_lost, 1);
        clear_rec();
        ph = int'($urandom_range(1, 4)) + 5 * int'($urandom_range(0, 1));
        #(ph);
        for (int i = 0; i < 4; i++) begin
            pwm_in = 1'b1;
            #2500;
            pwm_in = 1'b0;
            #7500;
        end
        @(negedge clk);
        check("async_count", pulse_duty_q.size(), 3);
        for (int i = 0; i < pulse_duty_q.size(); i++) begin
            check("async_duty_in_set", 32'(pulse_duty_q[i] == 24 || pulse_duty_q[i] == 25), 1);
            check("async_period_in_set",
                  32'(pulse_per_q[i] >= 999 && pulse_per_q[i] <= 1001), 1);
            check("async_lost", pulse_lost_q[i], 0);
        end

        check("no_consecutive_valid", consec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
